// File: rtl/fb_wr_rgb565_pkg.sv
// Shared definitions for the RGB565 frame-buffer writer and the LCD scan-out side.
//   H_ACTIVE / V_ACTIVE : panel geometry (480x272), also used by the LCD controller
//   FB_ADDR_W           : frame-buffer address width, holds H_ACTIVE*V_ACTIVE-1
//   FB_DATA_W           : RGB565 word width
//   fb_wr_state_e       : writer FSM state encoding
//   rgb888_to_565       : truncating colour-depth reduction
package fb_wr_rgb565_pkg;

    localparam int H_ACTIVE  = 480;
    localparam int V_ACTIVE  = 272;
    localparam int FB_ADDR_W = 17;
    localparam int FB_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_WRITE    = 2'd2,
        ST_DONE     = 2'd3
    } fb_wr_state_e;

    // Plain truncation: the low bits are discarded, never rounded.
    function automatic logic [FB_DATA_W-1:0] rgb888_to_565(
        input logic [7:0] r,
        input logic [7:0] g,
        input logic [7:0] b
    );
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Raster position and frame-buffer address tracker for the frame writer.
//   clk, rst_n : clock, asynchronous active-low reset
//   step       : one pixel written at the current position (ignored when restart)
//   eol        : together with step, the pixel just written closes its line
//   restart    : the pixel just written was (0,0); position moves to (1,0)
//   x, y       : position of the next pixel to be written
//   addr       : frame-buffer address of the next pixel (y*H_ACTIVE + x)
//   last_pix   : next pixel is the final one of the frame
module fb_addr_gen #(
    parameter int H_ACTIVE = fb_wr_rgb565_pkg::H_ACTIVE,
    parameter int V_ACTIVE = fb_wr_rgb565_pkg::V_ACTIVE,
    parameter int ADDR_W   = fb_wr_rgb565_pkg::FB_ADDR_W,
    parameter int X_W      = $clog2(H_ACTIVE),
    parameter int Y_W      = $clog2(V_ACTIVE + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step,
    input  logic              eol,
    input  logic              restart,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic [ADDR_W-1:0] addr,
    output logic              last_pix
);

    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // The line base steps by H_ACTIVE per line so the address is never
    // formed with a multiplier; an early EOL simply jumps to the next base.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        base_d = base_q;
        addr_d = addr_q;
        if (restart) begin
            x_d    = X_W'(1);
            y_d    = '0;
            base_d = '0;
            addr_d = ADDR_W'(1);
        end else if (step) begin
            if (eol) begin
                x_d    = '0;
                y_d    = y_q + Y_W'(1);
                base_d = base_q + ADDR_W'(H_ACTIVE);
                addr_d = base_q + ADDR_W'(H_ACTIVE);
            end else begin
                x_d    = x_q + X_W'(1);
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            base_q <= '0;
            addr_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            base_q <= base_d;
            addr_q <= addr_d;
        end
    end

    assign x        = x_q;
    assign y        = y_q;
    assign addr     = addr_q;
    assign last_pix = (x_q == X_W'(H_ACTIVE - 1)) && (y_q == Y_W'(V_ACTIVE - 1));

endmodule

// File: rtl/fb_wr_rgb565.sv
// Frame-buffer writer: takes one RGB888 stream frame (valid/ready, SOF/EOL),
// converts to RGB565 and writes it at y*H_ACTIVE + x for the LCD scan-out.
//   iClk, iRsn              : clock, asynchronous active-low reset
//   iStart                  : arm one frame capture (IDLE only)
//   iPixValid/Sof/Eol/R/G/B : pixel stream beat
//   oPixReady               : beat accepted when iPixValid & oPixReady
//   oRamWrEn/Addr/Data      : registered RAM write port, one cycle after accept
//   oBusy                   : capture in progress (WAIT_SOF, WRITE, DONE)
//   oFrameDone              : pulse together with the final pixel's write
//   oErrLen                 : sticky framing error, cleared by iStart in IDLE
//
// state       | meaning
// ------------+-------------------------------------------------------
// ST_IDLE     | not armed, no beats accepted
// ST_WAIT_SOF | armed; non-SOF beats are dropped, SOF starts the frame
// ST_WRITE    | writing pixels, checking line length and stray SOF
// ST_DONE     | one cycle after the last pixel was accepted
module fb_wr_rgb565 #(
    parameter int H_ACTIVE = fb_wr_rgb565_pkg::H_ACTIVE,
    parameter int V_ACTIVE = fb_wr_rgb565_pkg::V_ACTIVE,
    parameter int ADDR_W   = fb_wr_rgb565_pkg::FB_ADDR_W
) (
    input  logic              iClk,
    input  logic              iRsn,
    input  logic              iStart,
    input  logic              iPixValid,
    input  logic              iPixSof,
    input  logic              iPixEol,
    input  logic [7:0]        iPixR,
    input  logic [7:0]        iPixG,
    input  logic [7:0]        iPixB,
    output logic              oPixReady,
    output logic              oRamWrEn,
    output logic [ADDR_W-1:0] oRamWrAddr,
    output logic [15:0]       oRamWrData,
    output logic              oBusy,
    output logic              oFrameDone,
    output logic              oErrLen
);

    import fb_wr_rgb565_pkg::*;

    localparam int X_W = $clog2(H_ACTIVE);
    localparam int Y_W = $clog2(V_ACTIVE + 1);

    fb_wr_state_e      state_q, state_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic              frame_done_q, frame_done_d;
    logic              err_len_q, err_len_d;

    logic              pix_ready;
    logic              accept;
    logic              ag_step;
    logic              ag_eol;
    logic              ag_restart;
    logic [X_W-1:0]    ag_x;
    logic [Y_W-1:0]    ag_y;
    logic [ADDR_W-1:0] ag_addr;
    logic              ag_last_pix;
    logic              x_at_end;
    logic              unused_y;

    fb_addr_gen #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .ADDR_W   (ADDR_W),
        .X_W      (X_W),
        .Y_W      (Y_W)
    ) u_addr_gen (
        .clk      (iClk),
        .rst_n    (iRsn),
        .step     (ag_step),
        .eol      (ag_eol),
        .restart  (ag_restart),
        .x        (ag_x),
        .y        (ag_y),
        .addr     (ag_addr),
        .last_pix (ag_last_pix)
    );

    // Row index is tracked for the address generator's own end-of-frame
    // detection; the writer itself only needs last_pix.
    assign unused_y = ^ag_y;

    assign pix_ready = (state_q == ST_WAIT_SOF) || (state_q == ST_WRITE);
    assign accept    = iPixValid && pix_ready;
    assign x_at_end  = (ag_x == X_W'(H_ACTIVE - 1));

    always_comb begin
        state_d      = state_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        err_len_d    = err_len_q;
        ag_step      = 1'b0;
        ag_eol       = 1'b0;
        ag_restart   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    err_len_d = 1'b0;
                    state_d   = ST_WAIT_SOF;
                end
            end

            ST_WAIT_SOF: begin
                if (accept && iPixSof) begin
                    ag_restart = 1'b1;
                    wr_en_d    = 1'b1;
                    wr_addr_d  = '0;
                    wr_data_d  = rgb888_to_565(iPixR, iPixG, iPixB);
                    state_d    = ST_WRITE;
                end
            end

            ST_WRITE: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = rgb888_to_565(iPixR, iPixG, iPixB);
                    if (iPixSof) begin
                        // Stray SOF restarts the frame; any EOL on the same beat is moot.
                        err_len_d  = 1'b1;
                        ag_restart = 1'b1;
                        wr_addr_d  = '0;
                    end else begin
                        wr_addr_d = ag_addr;
                        ag_step   = 1'b1;
                        // A missing EOL wraps exactly as a present one would.
                        ag_eol    = iPixEol || x_at_end;
                        if (iPixEol != x_at_end) begin
                            err_len_d = 1'b1;
                        end
                        if (ag_last_pix) begin
                            frame_done_d = 1'b1;
                            state_d      = ST_DONE;
                        end
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            state_q      <= ST_IDLE;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            err_len_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            err_len_q    <= err_len_d;
        end
    end

    assign oPixReady  = pix_ready;
    assign oRamWrEn   = wr_en_q;
    assign oRamWrAddr = wr_addr_q;
    assign oRamWrData = wr_data_q;
    assign oBusy      = (state_q != ST_IDLE);
    assign oFrameDone = frame_done_q;
    assign oErrLen    = err_len_q;

endmodule

// File: tb/tb_fb_wr_rgb565.sv
// Directed bench for fb_wr_rgb565. The DUT runs with a reduced 160x40 raster
// so whole frames stay short; all addresses are y*H + x of that raster.
module tb_fb_wr_rgb565;

    localparam int H  = 160;
    localparam int V  = 40;
    localparam int AW = 17;

    logic          iClk = 1'b0;
    logic          iRsn;
    logic          iStart;
    logic          iPixValid;
    logic          iPixSof;
    logic          iPixEol;
    logic [7:0]    iPixR, iPixG, iPixB;
    logic          oPixReady;
    logic          oRamWrEn;
    logic [AW-1:0] oRamWrAddr;
    logic [15:0]   oRamWrData;
    logic          oBusy;
    logic          oFrameDone;
    logic          oErrLen;

    int          n_chk     = 0;
    int          n_pass    = 0;
    int          last_addr = 0;
    logic [15:0] last_data = 16'h0000;

    always #5 iClk = ~iClk;

    fb_wr_rgb565 #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .ADDR_W   (AW)
    ) dut (
        .iClk       (iClk),
        .iRsn       (iRsn),
        .iStart     (iStart),
        .iPixValid  (iPixValid),
        .iPixSof    (iPixSof),
        .iPixEol    (iPixEol),
        .iPixR      (iPixR),
        .iPixG      (iPixG),
        .iPixB      (iPixB),
        .oPixReady  (oPixReady),
        .oRamWrEn   (oRamWrEn),
        .oRamWrAddr (oRamWrAddr),
        .oRamWrData (oRamWrData),
        .oBusy      (oBusy),
        .oFrameDone (oFrameDone),
        .oErrLen    (oErrLen)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // Drive one cycle; the write of a beat accepted on this edge is visible
    // right after it. Non-writing cycles must hold the last address/data.
    task automatic beat(input logic v, input logic sof, input logic eol,
                        input logic [23:0] rgb, input logic exp_wr,
                        input int exp_addr, input logic [15:0] exp_data,
                        input string tag);
        int          ea;
        logic [15:0] ed;
        iPixValid = v;
        iPixSof   = sof;
        iPixEol   = eol;
        {iPixR, iPixG, iPixB} = rgb;
        @(posedge iClk);
        #1;
        ea = exp_wr ? exp_addr : last_addr;
        ed = exp_wr ? exp_data : last_data;
        chk({tag, ".wr"},   32'(oRamWrEn),   32'(exp_wr));
        chk({tag, ".addr"}, 32'(oRamWrAddr), 32'(ea));
        chk({tag, ".data"}, 32'(oRamWrData), 32'(ed));
        if (exp_wr) begin
            last_addr = exp_addr;
            last_data = exp_data;
        end
    endtask

    // Stream n pixels from (x,y) with correct EOL marks; gap_pct inserts idle cycles.
    task automatic run_span(inout int x, inout int y, input int n, input int gap_pct,
                            input logic [23:0] rgb, input logic [15:0] d, input string tag);
        int k     = 0;
        int guard = 0;
        while (k < n && guard < n * 20) begin
            guard++;
            if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                beat(1'b0, 1'b0, 1'b0, rgb, 1'b0, 0, 16'h0, {tag, ".gap"});
            end else begin
                beat(1'b1, 1'b0, (x == H - 1), rgb, 1'b1, y * H + x, d, tag);
                k++;
                x++;
                if (x == H) begin
                    x = 0;
                    y++;
                end
            end
        end
        chk({tag, ".count"}, 32'(k), 32'(n));
    endtask

    task automatic start_frame();
        iStart = 1'b1;
        @(posedge iClk);
        #1;
        iStart = 1'b0;
    endtask

    task automatic idle_cycle();
        iPixValid = 1'b0;
        iPixSof   = 1'b0;
        iPixEol   = 1'b0;
        @(posedge iClk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int x, y;
        iRsn = 1'b0; iStart = 1'b0; iPixValid = 1'b0; iPixSof = 1'b0; iPixEol = 1'b0;
        iPixR = 8'h00; iPixG = 8'h00; iPixB = 8'h00;
        repeat (3) @(posedge iClk);
        #1;
        chk("rst.ready", 32'(oPixReady),  32'(0));
        chk("rst.wr",    32'(oRamWrEn),   32'(0));
        chk("rst.addr",  32'(oRamWrAddr), 32'(0));
        chk("rst.data",  32'(oRamWrData), 32'(0));
        chk("rst.busy",  32'(oBusy),      32'(0));
        chk("rst.done",  32'(oFrameDone), 32'(0));
        chk("rst.err",   32'(oErrLen),    32'(0));
        iRsn = 1'b1;
        idle_cycle();
        chk("idle.ready", 32'(oPixReady), 32'(0));

        // 1: full clean frame, 0xFF8007 -> 0xFC00
        start_frame();
        chk("t1.busy",  32'(oBusy),     32'(1));
        chk("t1.ready", 32'(oPixReady), 32'(1));
        beat(1'b1, 1'b1, 1'b0, 24'hFF8007, 1'b1, 0, 16'hFC00, "t1.sof");
        chk("t1.nodone", 32'(oFrameDone), 32'(0));
        x = 1; y = 0;
        run_span(x, y, H * V - 1, 0, 24'hFF8007, 16'hFC00, "t1");
        chk("t1.done",      32'(oFrameDone), 32'(1));
        chk("t1.lastaddr",  32'(oRamWrAddr), 32'(H * V - 1));
        chk("t1.donebusy",  32'(oBusy),      32'(1));
        chk("t1.doneready", 32'(oPixReady),  32'(0));
        chk("t1.err",       32'(oErrLen),    32'(0));
        idle_cycle();
        chk("t1.pulse", 32'(oFrameDone), 32'(0));
        chk("t1.idle",  32'(oBusy),      32'(0));
        chk("t1.wroff", 32'(oRamWrEn),   32'(0));

        // 2: beats ahead of SOF are dropped silently
        start_frame();
        for (int i = 0; i < 5; i++)
            beat(1'b1, 1'b0, (i == 2), 24'h123456, 1'b0, 0, 16'h0, "t2.drop");
        chk("t2.err", 32'(oErrLen), 32'(0));
        beat(1'b1, 1'b1, 1'b0, 24'h070307, 1'b1, 0, 16'h0000, "t2.sof");

        // 3: early EOL at x=100 on line 3, next beat lands on line 4
        x = 1; y = 0;
        run_span(x, y, 3 * H + 99, 0, 24'h123456, 16'h11AA, "t3");
        beat(1'b1, 1'b0, 1'b1, 24'h123456, 1'b1, 3 * H + 100, 16'h11AA, "t3.early");
        chk("t3.err", 32'(oErrLen), 32'(1));
        beat(1'b1, 1'b0, 1'b0, 24'h123456, 1'b1, 4 * H, 16'h11AA, "t3.next");
        x = 1; y = 4;
        run_span(x, y, H * V - (4 * H + 1), 0, 24'h123456, 16'h11AA, "t3.rest");
        chk("t3.done", 32'(oFrameDone), 32'(1));
        idle_cycle();
        chk("t3.errheld", 32'(oErrLen), 32'(1));
        start_frame();
        chk("t3.errclr", 32'(oErrLen), 32'(0));

        // 4: stray SOF at address 5000 restarts the frame at 0
        beat(1'b1, 1'b1, 1'b0, 24'h123456, 1'b1, 0, 16'h11AA, "t4.sof");
        x = 1; y = 0;
        run_span(x, y, 4999, 0, 24'h123456, 16'h11AA, "t4");
        chk("t4.noerr", 32'(oErrLen), 32'(0));
        beat(1'b1, 1'b1, 1'b1, 24'h080408, 1'b1, 0, 16'h0821, "t4.inject");
        chk("t4.err", 32'(oErrLen), 32'(1));
        x = 1; y = 0;
        run_span(x, y, H * V - 1, 0, 24'h080408, 16'h0821, "t4.rest");
        chk("t4.done", 32'(oFrameDone), 32'(1));
        idle_cycle();

        // 5: 50% valid gaps, then an early EOL to set the error flag
        start_frame();
        chk("t5.errclr", 32'(oErrLen), 32'(0));
        beat(1'b1, 1'b1, 1'b0, 24'hFFFFFF, 1'b1, 0, 16'hFFFF, "t5.sof");
        x = 1; y = 0;
        run_span(x, y, 300, 50, 24'hFFFFFF, 16'hFFFF, "t5");
        beat(1'b1, 1'b0, 1'b1, 24'hFFFFFF, 1'b1, 1 * H + 141, 16'hFFFF, "t5.early");
        chk("t5.err", 32'(oErrLen), 32'(1));

        // 6: asynchronous reset mid-line
        #3;
        iRsn = 1'b0;
        #1;
        chk("t6.ready", 32'(oPixReady),  32'(0));
        chk("t6.wr",    32'(oRamWrEn),   32'(0));
        chk("t6.addr",  32'(oRamWrAddr), 32'(0));
        chk("t6.data",  32'(oRamWrData), 32'(0));
        chk("t6.busy",  32'(oBusy),      32'(0));
        chk("t6.done",  32'(oFrameDone), 32'(0));
        chk("t6.err",   32'(oErrLen),    32'(0));
        @(posedge iClk);
        #1;
        iRsn = 1'b1;
        last_addr = 0;
        last_data = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, 1'b1, 1'b0, 24'hFFFFFF, 1'b0, 0, 16'h0, "t6.noarm");
            chk("t6.noready", 32'(oPixReady), 32'(0));
        end
        start_frame();
        beat(1'b1, 1'b1, 1'b0, 24'h123456, 1'b1, 0, 16'h11AA, "t6.sof");
        x = 1; y = 0;
        run_span(x, y, 2, 0, 24'h123456, 16'h11AA, "t6.next");
        idle_cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
